regfile_writeback_unit: RTL and testbench
=========================================

// Module: regfile_writeback_unit
// PURPOSE
//  Write-side master for the 32x32 register file: merges ALU results (single-cycle, never stalled)
//  and load/memory responses (valid/ready) into the single write port. Loads are buffered in a small
//  FIFO while the ALU holds the port. Drops x0 writes, squashes stale loads and supplies forwarding
//  data for in-flight writes to the decode-stage read ports.
// PARAMETERS
//  DATA_W  32  width of register data
//  ADDR_W  5   register address width (32 registers)
//  DEPTH   4   load FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1                 clock, all state updates on rising edge
//  rst_n         in   1                 asynchronous, active-low reset
//  aluValid      in   1                 ALU result present this cycle
//  aluAddress    in   ADDR_W            ALU destination register
//  aluData       in   DATA_W            ALU result
//  memValid      in   1                 load response present
//  memReady      out  1                 unit can accept load response (= !fifoFull)
//  memAddress    in   ADDR_W            load destination register
//  memData       in   DATA_W            load data
//  writeEnable   out  1                 register-file write strobe (registered)
//  writeAddress  out  ADDR_W            register-file write address (registered)
//  writeData     out  DATA_W            register-file write data (registered)
//  fwdAddress1/2 in   ADDR_W            decode read addresses to check against in-flight writes
//  fwdHit1/2     out  1                 in-flight write to fwdAddressN exists
//  fwdData1/2    out  DATA_W            newest in-flight value for fwdAddressN, 0 when no hit
//  pendingCount  out  $clog2(DEPTH+1)   FIFO occupancy (squashed entries included)
// BEHAVIOUR
//  - Reset (rst_n low, async): FIFO empty, all entries invalid, writeEnable/writeAddress/writeData=0,
//    pendingCount=0, memReady=1. Reset mid-operation discards every pending write; no partial write.
//  - Load accept: memValid && memReady at edge k -> entry {addr,data,valid=(memAddress!=0)} pushed.
//    memReady=!full purely from occupancy; no push-through when full even if a pop occurs same cycle.
//  - Port arbitration each edge (ALU highest priority):
//    1) aluValid && aluAddress!=0 -> output reg <= {1,aluAddress,aluData}; FIFO not popped.
//    2) else FIFO non-empty -> pop head; output reg <= {head.valid,head.addr,head.data}
//       (squashed/x0 head pops with writeEnable=0, still consumes the cycle).
//    3) else writeEnable <= 0 (writeAddress/writeData hold last values).
//    aluValid with aluAddress==0 counts as idle: FIFO may pop that cycle.
//  - Latency: ALU result -> writeEnable high 1 cycle later. Load -> earliest 2 cycles after accept;
//    FIFO drains strictly in arrival order, one entry per cycle when ALU idle.
//  - Squash: ALU write to register r (r!=0) at edge k clears valid of every FIFO entry with addr r,
//    including a load to r accepted at the same edge k (ALU result is the newer value).
//  - Forwarding (combinational, per port N): fwdAddressN==0 -> no hit. Else youngest valid FIFO entry
//    with matching addr wins; otherwise output reg if writeEnable && writeAddress==fwdAddressN.
//    Sources are state only; current-cycle aluValid/memValid inputs are not forwarded.
//  - pendingCount = push - pop occupancy, wraps never (push blocked at DEPTH, pop blocked at 0).
//  - Simultaneous push and pop: occupancy unchanged, pointers both advance modulo DEPTH.
// TESTING
//  1 ALU x5=0x00001234 at edge 1 -> edge 2: writeEnable=1, writeAddress=5, writeData=0x00001234.
//  2 ALU x0=0xDEADBEEF; load x0=0x55 -> writeEnable never 1; load entry pops with writeEnable=0.
//  3 ALU idle, load x6=0xAA accepted edge 1 -> writeEnable=1, addr 6, data 0xAA after edge 2.
//  4 ALU valid every cycle (x1..), 5 loads offered -> memReady=0 after 4th, pendingCount=4;
//    ALU stops -> 4 loads written in order on 4 consecutive cycles, then memReady=1, count=0.
//  5 Load x7=0x11 queued, then ALU x7=0x22 -> only 0x22 written to x7; pending entry pops with WE=0.
//  6 Loads x8=0x1, x8=0x2 queued, fwdAddress1=8 -> fwdHit1=1, fwdData1=0x2; fwdAddress2=0 -> hit 0;
//    assert rst_n low mid-drain -> outputs 0, count 0 immediately, no further writes.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// Register-file write-side master: merges single-cycle ALU results and buffered load responses
// into one registered write port, squashes stale loads and forwards in-flight writes to decode.
module regfile_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aluValid,
  input  logic [ADDR_W-1:0]          aluAddress,
  input  logic [DATA_W-1:0]          aluData,
  input  logic                       memValid,
  output logic                       memReady,
  input  logic [ADDR_W-1:0]          memAddress,
  input  logic [DATA_W-1:0]          memData,
  output logic                       writeEnable,
  output logic [ADDR_W-1:0]          writeAddress,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          fwdAddress1,
  input  logic [ADDR_W-1:0]          fwdAddress2,
  output logic                       fwdHit1,
  output logic                       fwdHit2,
  output logic [DATA_W-1:0]          fwdData1,
  output logic [DATA_W-1:0]          fwdData2,
  output logic [$clog2(DEPTH+1)-1:0] pendingCount
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a load transfers on a rising edge where memValid && memReady; memReady
  // depends only on occupancy, so a pop in the same cycle never frees a slot early.

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [DEPTH-1:0]  fifo_vld_q, fifo_vld_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic alu_wr, full, push, pop;

  assign alu_wr = aluValid && (aluAddress != '0);
  assign full   = (count_q == CW'(DEPTH));
  assign push   = memValid && !full;
  assign pop    = !alu_wr && (count_q != '0);

  assign memReady     = !full;
  assign writeEnable  = we_q;
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;
  assign pendingCount = count_q;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    // The ALU result is newer than anything queued for the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_wr && (fifo_addr_q[i] == aluAddress)) fifo_vld_d[i] = 1'b0;
    end

    if (pop) begin
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end

    if (push) begin
      fifo_addr_d[wr_ptr_q] = memAddress;
      fifo_data_d[wr_ptr_q] = memData;
      fifo_vld_d[wr_ptr_q]  = (memAddress != '0) && !(alu_wr && (memAddress == aluAddress));
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (alu_wr) begin
      we_d    = 1'b1;
      waddr_d = aluAddress;
      wdata_d = aluData;
    end else if (pop) begin
      we_d    = fifo_vld_q[rd_ptr_q];
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Forwarding walks entries oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && fifo_vld_q[idx]) begin
        if ((fwdAddress1 != '0) && (fifo_addr_q[idx] == fwdAddress1)) begin
          fwdHit1  = 1'b1;
          fwdData1 = fifo_data_q[idx];
        end
        if ((fwdAddress2 != '0) && (fifo_addr_q[idx] == fwdAddress2)) begin
          fwdHit2  = 1'b1;
          fwdData2 = fifo_data_q[idx];
        end
      end
    end
    if (!fwdHit1 && (fwdAddress1 != '0) && we_q && (waddr_q == fwdAddress1)) begin
      fwdHit1  = 1'b1;
      fwdData1 = wdata_q;
    end
    if (!fwdHit2 && (fwdAddress2 != '0) && we_q && (waddr_q == fwdAddress2)) begin
      fwdHit2  = 1'b1;
      fwdData2 = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_vld_q  <= fifo_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed scenarios plus a randomized run against a
// queue-based model of the pending-write list and the registered write port.
module tb_regfile_writeback_unit;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aluValid = 1'b0;
  logic [AW-1:0] aluAddress = '0;
  logic [DW-1:0] aluData = '0;
  logic          memValid = 1'b0;
  logic          memReady;
  logic [AW-1:0] memAddress = '0;
  logic [DW-1:0] memData = '0;
  logic          writeEnable;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;
  logic [AW-1:0] fwdAddress1 = '0;
  logic [AW-1:0] fwdAddress2 = '0;
  logic          fwdHit1, fwdHit2;
  logic [DW-1:0] fwdData1, fwdData2;
  logic [CW-1:0] pendingCount;

  int vectors = 0;
  int miscompares = 0;

  regfile_writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluAddress(aluAddress), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memAddress(memAddress), .memData(memData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .fwdAddress1(fwdAddress1), .fwdAddress2(fwdAddress2),
    .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
    .pendingCount(pendingCount)
  );

  always #5 clk = ~clk;

  // Reference model: list of pending loads in arrival order plus the write-port register.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid;
  } ent_t;

  ent_t          exp_q[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    exp_q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic logic [DW:0] model_fwd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].valid && exp_q[i].addr == a) return {1'b1, exp_q[i].data};
    if (m_we && m_addr == a) return {1'b1, m_data};
    return '0;
  endfunction

  // Driver: apply one cycle of inputs, advance the model at the edge, settle 1 time unit after.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    logic alu_wr, do_push;
    ent_t e;
    aluValid = av; aluAddress = aa; aluData = ad;
    memValid = mv; memAddress = ma; memData = md;
    @(posedge clk);
    alu_wr  = av && (aa != '0);
    do_push = mv && (exp_q.size() < DEPTH);
    if (alu_wr)
      foreach (exp_q[i]) if (exp_q[i].addr == aa) exp_q[i].valid = 1'b0;
    if (alu_wr) begin
      m_we = 1'b1; m_addr = aa; m_data = ad;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_we = e.valid; m_addr = e.addr; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (do_push) begin
      e.addr = ma; e.data = md; e.valid = (ma != '0) && !(alu_wr && ma == aa);
      exp_q.push_back(e);
    end
    #1;
    aluValid = 1'b0;
    memValid = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({writeEnable, writeAddress, writeData} !== '0) begin
      miscompares++;
      $display("FAIL reset_wport: we=%0b addr=%0d data=%h required 0", writeEnable, writeAddress, writeData);
    end
    vectors++;
    if (pendingCount !== '0 || memReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_fifo: count=%0d ready=%0b required 0/1", pendingCount, memReady);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_basic();
    cycle(1, 5, 32'h0000_1234, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b1 || writeAddress !== 5'd5 || writeData !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL alu_write: we=%0b addr=%0d data=%h required 1/5/00001234", writeEnable, writeAddress, writeData);
    end
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b0 || writeAddress !== 5'd5 || writeData !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL alu_idle_hold: we=%0b addr=%0d data=%h required 0/5/00001234", writeEnable, writeAddress, writeData);
    end
  endtask

  task automatic test_x0();
    cycle(1, 0, 32'hDEAD_BEEF, 1, 0, 32'h55);
    vectors++;
    if (writeEnable !== 1'b0 || pendingCount !== 3'd1) begin
      miscompares++;
      $display("FAIL x0_alu: we=%0b count=%0d required 0/1", writeEnable, pendingCount);
    end
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b0 || pendingCount !== 3'd0) begin
      miscompares++;
      $display("FAIL x0_load_pop: we=%0b count=%0d required 0/0", writeEnable, pendingCount);
    end
  endtask

  task automatic test_load_basic();
    cycle(0, 0, 0, 1, 6, 32'hAA);
    vectors++;
    if (writeEnable !== 1'b0 || pendingCount !== 3'd1) begin
      miscompares++;
      $display("FAIL load_edge1: we=%0b count=%0d required 0/1", writeEnable, pendingCount);
    end
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b1 || writeAddress !== 5'd6 || writeData !== 32'hAA || pendingCount !== 3'd0) begin
      miscompares++;
      $display("FAIL load_edge2: we=%0b addr=%0d data=%h count=%0d required 1/6/aa/0",
               writeEnable, writeAddress, writeData, pendingCount);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (memReady !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_ready_%0d: ready=%0b required 1", i, memReady);
      end
      cycle(1, AW'(i + 1), $urandom, 1, AW'(10 + i), DW'(32'h100 + i));
    end
    vectors++;
    if (memReady !== 1'b0 || pendingCount !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_full: ready=%0b count=%0d required 0/4", memReady, pendingCount);
    end
    cycle(1, 5, $urandom, 1, 14, 32'h104);
    vectors++;
    if (pendingCount !== 3'd4 || writeAddress !== 5'd5) begin
      miscompares++;
      $display("FAIL bp_no_push: count=%0d addr=%0d required 4/5", pendingCount, writeAddress);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      vectors++;
      if (writeEnable !== 1'b1 || writeAddress !== AW'(10 + i) || writeData !== DW'(32'h100 + i)) begin
        miscompares++;
        $display("FAIL bp_drain_%0d: we=%0b addr=%0d data=%h required 1/%0d/%h",
                 i, writeEnable, writeAddress, writeData, 10 + i, 32'h100 + i);
      end
    end
    vectors++;
    if (memReady !== 1'b1 || pendingCount !== 3'd0) begin
      miscompares++;
      $display("FAIL bp_empty: ready=%0b count=%0d required 1/0", memReady, pendingCount);
    end
  endtask

  task automatic test_squash();
    fwdAddress1 = 7;
    fwdAddress2 = 0;
    cycle(1, 1, 32'h9, 1, 7, 32'h11);
    vectors++;
    if (fwdHit1 !== 1'b1 || fwdData1 !== 32'h11) begin
      miscompares++;
      $display("FAIL squash_fwd_pre: hit=%0b data=%h required 1/11", fwdHit1, fwdData1);
    end
    cycle(1, 7, 32'h22, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b1 || writeAddress !== 5'd7 || writeData !== 32'h22 || pendingCount !== 3'd1) begin
      miscompares++;
      $display("FAIL squash_alu: we=%0b addr=%0d data=%h count=%0d required 1/7/22/1",
               writeEnable, writeAddress, writeData, pendingCount);
    end
    vectors++;
    if (fwdHit1 !== 1'b1 || fwdData1 !== 32'h22) begin
      miscompares++;
      $display("FAIL squash_fwd_post: hit=%0b data=%h required 1/22", fwdHit1, fwdData1);
    end
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b0 || pendingCount !== 3'd0) begin
      miscompares++;
      $display("FAIL squash_pop: we=%0b count=%0d required 0/0", writeEnable, pendingCount);
    end
  endtask

  task automatic test_forward_reset();
    fwdAddress1 = 8;
    fwdAddress2 = 0;
    cycle(1, 1, 32'h3, 1, 8, 32'h1);
    cycle(1, 2, 32'h4, 1, 8, 32'h2);
    vectors++;
    if (fwdHit1 !== 1'b1 || fwdData1 !== 32'h2 || pendingCount !== 3'd2) begin
      miscompares++;
      $display("FAIL fwd_youngest: hit=%0b data=%h count=%0d required 1/2/2", fwdHit1, fwdData1, pendingCount);
    end
    vectors++;
    if (fwdHit2 !== 1'b0 || fwdData2 !== '0) begin
      miscompares++;
      $display("FAIL fwd_x0: hit=%0b data=%h required 0/0", fwdHit2, fwdData2);
    end
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b1 || writeAddress !== 5'd8 || writeData !== 32'h1 || pendingCount !== 3'd1) begin
      miscompares++;
      $display("FAIL drain_first: we=%0b addr=%0d data=%h count=%0d required 1/8/1/1",
               writeEnable, writeAddress, writeData, pendingCount);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({writeEnable, writeAddress, writeData} !== '0 || pendingCount !== '0 || memReady !== 1'b1 || fwdHit1 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: we=%0b addr=%0d data=%h count=%0d ready=%0b hit1=%0b required all idle",
               writeEnable, writeAddress, writeData, pendingCount, memReady, fwdHit1);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (writeEnable !== 1'b0 || pendingCount !== '0) begin
      miscompares++;
      $display("FAIL post_reset: we=%0b count=%0d required 0/0", writeEnable, pendingCount);
    end
  endtask

  task automatic test_random();
    logic [DW:0] f1, f2;
    for (int n = 0; n < 400; n++) begin
      fwdAddress1 = AW'($urandom_range(0, 7));
      fwdAddress2 = AW'($urandom_range(0, 7));
      vectors++;
      if (memReady !== (exp_q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL rnd_ready @%0d: ready=%0b required %0b", n, memReady, exp_q.size() < DEPTH);
      end
      cycle(($urandom_range(0, 99) < 45), AW'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom);
      vectors++;
      if (writeEnable !== m_we || writeAddress !== m_addr || writeData !== m_data) begin
        miscompares++;
        $display("FAIL rnd_wport @%0d: we=%0b addr=%0d data=%h required %0b/%0d/%h",
                 n, writeEnable, writeAddress, writeData, m_we, m_addr, m_data);
      end
      vectors++;
      if (pendingCount !== CW'(exp_q.size())) begin
        miscompares++;
        $display("FAIL rnd_count @%0d: count=%0d required %0d", n, pendingCount, exp_q.size());
      end
      f1 = model_fwd(fwdAddress1);
      f2 = model_fwd(fwdAddress2);
      vectors++;
      if ({fwdHit1, fwdData1} !== f1 || {fwdHit2, fwdData2} !== f2) begin
        miscompares++;
        $display("FAIL rnd_fwd @%0d: p1=%0b/%h p2=%0b/%h required %0b/%h %0b/%h",
                 n, fwdHit1, fwdData1, fwdHit2, fwdData2, f1[DW], f1[DW-1:0], f2[DW], f2[DW-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_x0();
    test_load_basic();
    test_back_to_back();
    test_squash();
    test_forward_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
